// File: rtl/soc_mmio.sv
`default_nettype none
// ============================================================================
// Module      : soc_mmio
// Description : Memory-mapped I/O bridge between the processor bus and RAM.
//               Address bit IO_BIT splits the bus into a RAM region (bit = 0)
//               and an I/O page (bit = 1). The I/O page hosts byte-writable
//               GPIO outputs with set/clear aliases, two-flop synchronised
//               GPIO inputs and a free-running 64-bit cycle counter with a
//               high-word snapshot. Reads have one cycle of latency, matching
//               the RAM, and share a single return path to the processor.
//               Optional compare timer enabled by defining SOC_MMIO_TIMER_EN.
// Ports       : clk, resetn (async, active low)
//               cpu_addr/cpu_rstrb/cpu_wdata/cpu_wmask -> processor request
//               cpu_rdata                              <- processor read data
//               ram_rstrb/ram_wmask -> gated strobes to RAM, ram_rdata <- RAM
//               gpio_out -> GPIO outputs, gpio_in <- async GPIO inputs
//               irq -> timer interrupt (0 unless SOC_MMIO_TIMER_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module soc_mmio #(
    parameter int XLEN   = 32,
    parameter int NGPIO  = 8,
    parameter int IO_BIT = 22
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [XLEN-1:0]  cpu_addr,
    input  logic             cpu_rstrb,
    input  logic [XLEN-1:0]  cpu_wdata,
    input  logic [3:0]       cpu_wmask,
    output logic [XLEN-1:0]  cpu_rdata,
    output logic             ram_rstrb,
    output logic [3:0]       ram_wmask,
    input  logic [XLEN-1:0]  ram_rdata,
    output logic [NGPIO-1:0] gpio_out,
    input  logic [NGPIO-1:0] gpio_in,
    output logic             irq
);

    localparam logic [2:0] C_OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] C_OFF_GPIO_SET = 3'd1;
    localparam logic [2:0] C_OFF_GPIO_CLR = 3'd2;
    localparam logic [2:0] C_OFF_GPIO_IN  = 3'd3;
    localparam logic [2:0] C_OFF_CYC_LO   = 3'd4;
    localparam logic [2:0] C_OFF_CYC_HI   = 3'd5;
    localparam logic [2:0] C_OFF_TMR_CMP  = 3'd6;
    localparam logic [2:0] C_OFF_TMR_STAT = 3'd7;

    logic              w_io_sel;
    logic [2:0]        w_off;
    logic              w_io_wr;
    logic [XLEN-1:0]   w_bmask;
    logic [XLEN-1:0]   w_gpio_ext;
    logic [XLEN-1:0]   w_gpin_ext;
    logic [XLEN-1:0]   w_rd_val;
    logic [NGPIO-1:0]  w_gpio_nxt;

    logic [NGPIO-1:0]  r_gpio_out;
    logic [NGPIO-1:0]  r_sync1;
    logic [NGPIO-1:0]  r_sync2;
    logic [63:0]       r_cycle;
    logic [31:0]       r_hi_snap;
    logic              r_rd_io;
    logic [XLEN-1:0]   r_io_q;

    // Address and data bits not used by the decode on every build.
    logic              w_unused;
    assign w_unused = ^{cpu_addr, cpu_wdata};

    assign w_io_sel = cpu_addr[IO_BIT];
    assign w_off    = cpu_addr[4:2];
    assign w_io_wr  = w_io_sel && (cpu_wmask != 4'd0);

    // RAM only sees requests aimed at the RAM region.
    assign ram_rstrb = cpu_rstrb & ~w_io_sel;
    assign ram_wmask = w_io_sel ? 4'd0 : cpu_wmask;

    // Expand the 4-bit byte mask into a per-bit mask.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_bmask[8*i +: 8] = {8{cpu_wmask[i]}};
    end

    always_comb begin
        w_gpio_ext             = '0;
        w_gpio_ext[NGPIO-1:0]  = r_gpio_out;
        w_gpin_ext             = '0;
        w_gpin_ext[NGPIO-1:0]  = r_sync2;
    end

    always_comb begin
        w_gpio_nxt = r_gpio_out;
        if (w_io_wr) begin
            case (w_off)
                C_OFF_GPIO_OUT: w_gpio_nxt = (r_gpio_out & ~w_bmask[NGPIO-1:0])
                                           | (cpu_wdata[NGPIO-1:0] & w_bmask[NGPIO-1:0]);
                C_OFF_GPIO_SET: w_gpio_nxt = r_gpio_out | cpu_wdata[NGPIO-1:0];
                C_OFF_GPIO_CLR: w_gpio_nxt = r_gpio_out & ~cpu_wdata[NGPIO-1:0];
                default:        w_gpio_nxt = r_gpio_out;
            endcase
        end
    end

`ifdef SOC_MMIO_TIMER_EN
    logic [31:0] r_cmp;
    logic        r_en;
    logic        r_flag;
    logic        r_irq;
    logic [31:0] w_cmp_nxt;
    logic        w_stat_wr;
    logic        w_en_nxt;
    logic        w_flag_nxt;

    assign w_cmp_nxt = (w_io_wr && w_off == C_OFF_TMR_CMP)
                     ? ((r_cmp & ~w_bmask) | (cpu_wdata & w_bmask)) : r_cmp;
    assign w_stat_wr = w_io_wr && (w_off == C_OFF_TMR_STAT) && cpu_wmask[0];
    assign w_en_nxt  = w_stat_wr ? cpu_wdata[1] : r_en;

    // A match in the same cycle as a write-1-to-clear keeps the flag set.
    always_comb begin
        w_flag_nxt = r_flag;
        if (w_stat_wr && cpu_wdata[0]) begin
            w_flag_nxt = 1'b0;
        end
        if (r_en && (r_cycle[31:0] == r_cmp)) begin
            w_flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmp  <= '0;
            r_en   <= 1'b0;
            r_flag <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_cmp  <= w_cmp_nxt;
            r_en   <= w_en_nxt;
            r_flag <= w_flag_nxt;
            r_irq  <= w_flag_nxt & w_en_nxt;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            C_OFF_GPIO_OUT: w_rd_val = w_gpio_ext;
            C_OFF_GPIO_IN:  w_rd_val = w_gpin_ext;
            C_OFF_CYC_LO:   w_rd_val = r_cycle[31:0];
            C_OFF_CYC_HI:   w_rd_val = r_hi_snap;
`ifdef SOC_MMIO_TIMER_EN
            C_OFF_TMR_CMP:  w_rd_val = r_cmp;
            C_OFF_TMR_STAT: w_rd_val = {30'd0, r_en, r_flag};
`endif
            default:        w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cycle    <= '0;
            r_hi_snap  <= '0;
            r_rd_io    <= 1'b0;
            r_io_q     <= '0;
        end else begin
            r_gpio_out <= w_gpio_nxt;
            r_sync1    <= gpio_in;
            r_sync2    <= r_sync1;
            r_cycle    <= r_cycle + 64'd1;
            if (cpu_rstrb) begin
                r_rd_io <= w_io_sel;
                if (w_io_sel) begin
                    r_io_q <= w_rd_val;
                end
            end
            // Reading the low word freezes the high word so a LO/HI pair is coherent.
            if (cpu_rstrb && w_io_sel && (w_off == C_OFF_CYC_LO)) begin
                r_hi_snap <= r_cycle[63:32];
            end
        end
    end

    assign cpu_rdata = r_rd_io ? r_io_q : ram_rdata;
    assign gpio_out  = r_gpio_out;

endmodule
`default_nettype wire

// File: doc/soc_mmio.md
Name: soc_mmio

Overview:
Parametrised memory-mapped I/O bridge between the processor bus and the RAM in the SoC top level.
- Decodes one address bit to split the bus into a RAM region and an I/O page.
- Hosts byte-writable GPIO outputs, synchronised GPIO inputs and a 64-bit cycle counter.
- Presents a single read-data return to the processor, with the same one-cycle read latency as the RAM.

Parameters:
XLEN, 32, bus data/address width (only 32 supported)
NGPIO, 8, number of GPIO output and input bits (1..32)
IO_BIT, 22, address bit that selects the I/O page when 1

Ports:
clk  input  1  system clock (divided SoC clock)
resetn  input  1  asynchronous active-low reset
cpu_addr  input  XLEN  processor byte address
cpu_rstrb  input  1  read strobe, one cycle per read
cpu_wdata  input  XLEN  write data
cpu_wmask  input  4  byte write enables; nonzero means write
cpu_rdata  output  XLEN  read data returned to processor
ram_rstrb  output  1  read strobe forwarded to RAM
ram_wmask  output  4  write mask forwarded to RAM
ram_rdata  input  XLEN  RAM read data, valid the cycle after ram_rstrb
gpio_out  output  NGPIO  GPIO output register
gpio_in  input  NGPIO  asynchronous GPIO inputs
irq  output  1  timer interrupt (0 when SOC_MMIO_TIMER_EN is undefined)

Behaviour:
- Decode: io_sel = cpu_addr[IO_BIT]. Register offset = cpu_addr[4:2].
- RAM gating (combinational):
  - ram_rstrb = cpu_rstrb & ~io_sel.
  - ram_wmask = io_sel ? 0 : cpu_wmask.
  - cpu_wdata and cpu_addr go to RAM unmodified.
- Register map (offset, access, function):
  - 0x00 GPIO_OUT, RW: byte-lane write honouring cpu_wmask; bits >= NGPIO read 0.
  - 0x04 GPIO_SET, WO: gpio_out |= wdata[NGPIO-1:0] when any wmask bit is set.
  - 0x08 GPIO_CLR, WO: gpio_out &= ~wdata[NGPIO-1:0] when any wmask bit is set.
  - 0x0C GPIO_IN, RO: two-flop synchronised gpio_in.
  - 0x10 CYCLE_LO, RO: counter[31:0]; this read also latches counter[63:32] into the hi snapshot register.
  - 0x14 CYCLE_HI, RO: returns the hi snapshot register.
  - 0x18 TIMER_CMP and 0x1C TIMER_STAT: only with the optional feature, otherwise read 0.
  - Reads of write-only or unmapped offsets return 0; writes to them are ignored.
- Read path:
  - On cpu_rstrb, register rd_io <= io_sel, and if io_sel, io_q <= selected register value.
  - cpu_rdata = rd_io ? io_q : ram_rdata, valid the cycle after cpu_rstrb.
  - rd_io and io_q hold until the next cpu_rstrb.
- Read and write in the same cycle: both are performed; the read returns the pre-write value.
- Cycle counter: 64-bit, increments every clk, wraps from all-ones to 0 with no flag.
- Reset (asynchronous, any time including mid-read):
  - gpio_out=0, both sync flops=0, counter=0, hi snapshot=0, rd_io=0, io_q=0, irq=0.
  - cpu_rdata then follows ram_rdata.
  - A read in flight during reset is lost; the processor re-issues it.

Optional Feature:
Macro SOC_MMIO_TIMER_EN.
- When defined:
  - TIMER_CMP (0x18, RW, byte-lane) holds a 32-bit compare value.
  - TIMER_STAT (0x1C): bit1 = enable (RW), bit0 = flag.
  - Flag is set when enable=1 and counter[31:0] == TIMER_CMP. It is sticky.
  - Writing 1 to bit0 clears the flag. If a clear and a match occur in the same cycle, set wins.
  - irq = flag & enable, registered. Reset clears TIMER_CMP, enable and flag.
- When undefined: no compare logic; 0x18/0x1C read 0, writes are ignored, irq tied to 0.

Test Plan:
- Reset, then read RAM address 0x100 (RAM preloaded 0xDEADBEEF) -> ram_rstrb pulses, cpu_rdata=0xDEADBEEF one cycle later, gpio_out=0.
- Write GPIO_OUT=0xA5 with wmask=0xF at address 0x400000, then SET 0x0A, then CLR 0x81 -> gpio_out sequence 0xA5, 0xAF, 0x2E; ram_wmask stays 0 throughout.
- Drive gpio_in=0x3C; read GPIO_IN two cycles later -> 0x3C. A read issued one cycle after the input change -> returns the old value.
- Force counter to 0x0000_0001_FFFF_FFFF, read CYCLE_LO then CYCLE_HI -> LO=0xFFFF_FFFF, HI=1; snapshot is not affected by the wrap.
- SOC_MMIO_TIMER_EN: CMP=50, enable=1 -> irq rises when counter reaches 50; clearing bit0 drops irq; clear coinciding with a match -> irq stays 1.
- Assert resetn=0 one cycle after an I/O read strobe -> cpu_rdata follows ram_rdata, all outputs 0.
